cache_controller: RTL

//  MEM-stage front end for the 2-way data cache. Maps MEM byte addresses onto cache and SRAM addresses.

---
 rtl/cache_ctrl_pkg.sv | 37 +++
 rtl/cache_ctrl_stats.sv | 39 +++
 rtl/cache_controller.sv | 130 +++++++++++++
 3 files changed

// File: rtl/cache_ctrl_pkg.sv
// Shared types, widths and address helpers for the MEM-stage data-cache front end.
// Line fetch word selection and BASE_ADDR-relative address slicing live here.
package cache_ctrl_pkg;

   localparam int unsigned AW  = 32;
   localparam int unsigned CAW = 19;
   localparam int unsigned SAW = 18;

   localparam logic [AW-1:0] BASE_ADDR_DEF = 32'd1024;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_WAIT = 3'd1,
      FILL    = 3'd2,
      WR_WAIT = 3'd3,
      WR_DONE = 3'd4
   } state_e;

   function automatic logic [AW-1:0] eff_addr(input logic [AW-1:0] a,
                                              input logic [AW-1:0] base);
      return a - base;
   endfunction

   function automatic logic [CAW-1:0] cache_slice(input logic [AW-1:0] e);
      return e[CAW-1:0];
   endfunction

   function automatic logic [SAW-1:0] sram_slice(input logic [AW-1:0] e);
      return e[SAW+2:3];
   endfunction

   function automatic logic [31:0] word_pick(input logic [63:0] line,
                                             input logic        sel);
      return sel ? line[63:32] : line[31:0];
   endfunction

endpackage

// File: rtl/cache_ctrl_stats.sv
// Saturating hit/miss counter pair for the data-cache front end.
// Both counters clear on synchronous active-low reset and stick at all-ones.
module cache_ctrl_stats (
   input  logic        clk,
   input  logic        rst,
   input  logic        hit_i,
   input  logic        miss_i,
   output logic [31:0] hit_cnt_o,
   output logic [31:0] miss_cnt_o
);

   logic [31:0] hit_q, hit_d;
   logic [31:0] miss_q, miss_d;

   always_comb begin
      hit_d  = hit_q;
      miss_d = miss_q;
      if (hit_i && (hit_q != '1)) begin
         hit_d = hit_q + 32'd1;
      end
      if (miss_i && (miss_q != '1)) begin
         miss_d = miss_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         hit_q  <= '0;
         miss_q <= '0;
      end else begin
         hit_q  <= hit_d;
         miss_q <= miss_d;
      end
   end

   assign hit_cnt_o  = hit_q;
   assign miss_cnt_o = miss_q;

endmodule

// File: rtl/cache_controller.sv
// MEM-stage front end for the 2-way data cache: write-through, no-write-allocate.
// Define CACHE_CTRL_STATS_EN to add saturating hit_cnt/miss_cnt outputs.
module cache_controller
   import cache_ctrl_pkg::*;
#(
   parameter logic [AW-1:0] BASE_ADDR = BASE_ADDR_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            mem_r_en,
   input  logic            mem_w_en,
   input  logic [AW-1:0]   mem_addr,
   input  logic [31:0]     mem_wdata,
   output logic [31:0]     mem_rdata,
   output logic            ready,
   output logic [CAW-1:0]  cache_addr,
   output logic            cache_r_en,
   output logic            cache_w_en,
   output logic            cache_inv,
   output logic [31:0]     cache_wdata,
   input  logic            cache_hit,
   input  logic [31:0]     cache_rdata,
   output logic [SAW-1:0]  sram_addr,
   output logic            sram_r_en,
   output logic            sram_w_en,
   output logic [31:0]     sram_wdata,
   input  logic [63:0]     sram_rdata,
   input  logic            sram_ready
`ifdef CACHE_CTRL_STATS_EN
   ,
   output logic [31:0]     hit_cnt,
   output logic [31:0]     miss_cnt
`endif
);

   state_e        state_q, state_d;
   logic [31:0]   line_q, line_d;
   logic [AW-1:0] eff;
   logic          unused_eff;

   assign eff        = eff_addr(mem_addr, BASE_ADDR);
   assign unused_eff = ^{eff[AW-1:SAW+3], eff[1:0]};

   always_comb begin
      state_d    = state_q;
      line_d     = line_q;
      ready      = 1'b1;
      mem_rdata  = cache_rdata;
      cache_r_en = 1'b0;
      cache_w_en = 1'b0;
      cache_inv  = 1'b0;
      sram_r_en  = 1'b0;
      sram_w_en  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (mem_w_en) begin
               ready      = 1'b0;
               cache_r_en = 1'b1;
               cache_inv  = cache_hit;
               state_d    = WR_WAIT;
            end else if (mem_r_en) begin
               cache_r_en = 1'b1;
               if (!cache_hit) begin
                  ready   = 1'b0;
                  state_d = RD_WAIT;
               end
            end
         end
         RD_WAIT: begin
            ready     = 1'b0;
            sram_r_en = 1'b1;
            if (sram_ready) begin
               line_d  = word_pick(sram_rdata, eff[2]);
               state_d = FILL;
            end
         end
         FILL: begin
            cache_w_en = 1'b1;
            mem_rdata  = line_q;
            state_d    = IDLE;
         end
         WR_WAIT: begin
            ready     = 1'b0;
            sram_w_en = 1'b1;
            if (sram_ready) begin
               state_d = WR_DONE;
            end
         end
         WR_DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         line_q  <= '0;
      end else begin
         state_q <= state_d;
         line_q  <= line_d;
      end
   end

   assign cache_addr  = cache_slice(eff);
   assign sram_addr   = sram_slice(eff);
   assign cache_wdata = line_q;
   assign sram_wdata  = mem_wdata;

`ifdef CACHE_CTRL_STATS_EN
   logic st_hit, st_miss;

   // Only reads started from IDLE count; stores take priority over loads.
   assign st_hit  = (state_q == IDLE) && mem_r_en && !mem_w_en && cache_hit;
   assign st_miss = (state_q == IDLE) && mem_r_en && !mem_w_en && !cache_hit;

   cache_ctrl_stats u_stats (
      .clk        (clk),
      .rst        (rst),
      .hit_i      (st_hit),
      .miss_i     (st_miss),
      .hit_cnt_o  (hit_cnt),
      .miss_cnt_o (miss_cnt)
   );
`endif

endmodule
